// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants and the fetch-stage state encoding. These are
// shared by the fetch stage and the decode-stage control unit.
package fetch_stage_pkg;

  localparam logic [5:0]  OPCODE_END = 6'b111111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_DRAIN  = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_end(input logic [31:0] instr);
    return instr[31:26] == OPCODE_END;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// if_id_register: the IF/ID pipeline register (instruction and PC+4).
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   en              load enable; when low the register holds
//   clr             when enabled, load a NOP and zero instead of the inputs
//   instr_in/pc4_in fetched word and its PC+4
//   instr_q/pc4_q   registered outputs (InstrD / PCPlus4D)
module if_id_register
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q
);

  // A hold (en low) wins over a clear, so a stalled decode never loses its word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else if (en) begin
      if (clr) begin
        instr_q <= NOP_INSTR;
        pc4_q   <= 32'h0;
      end else begin
        instr_q <= instr_in;
        pc4_q   <= pc4_in;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID register of the MIPS core.
// Holds the PC, addresses instruction memory, captures fetched words and
// sequences start, branch redirect, stalls and the END drain/halt.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   inicio                 start/hold; forces IDLE and clears the stage
//   StallF, StallD         hazard-unit holds for PC and IF/ID
//   PCSrcD, PCBranchD      taken branch and its target, from decode
//   imem_addr, imem_rdata  instruction memory word address / read data
//   PCF                    current fetch PC
//   InstrD, PCPlus4D       IF/ID contents
//   halted                 END reached and pipeline drained
//   instr_count            number of words captured into IF/ID
//
// state     | meaning
// ----------+---------------------------------------------------------
// FS_IDLE   | held by inicio or just out of reset; nothing fetched
// FS_RUN    | normal fetch, honours stalls and branch redirects
// FS_DRAIN  | END captured; feed NOPs until later stages are empty
// FS_HALTED | program finished, all state frozen until inicio
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_ADDR_BITS = 8,
  parameter int          DRAIN_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inicio,
  input  logic                      StallF,
  input  logic                      StallD,
  input  logic                      PCSrcD,
  input  logic [31:0]               PCBranchD,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic [31:0]               PCF,
  output logic [31:0]               InstrD,
  output logic [31:0]               PCPlus4D,
  output logic                      halted,
  output logic [31:0]               instr_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  fetch_state_t state;
  logic [DW-1:0] drain_cnt;
  logic [31:0]   pc_plus4;
  logic          ifid_en;
  logic          ifid_clr;
  logic          capture;

  assign pc_plus4  = PCF + 32'd4;
  assign imem_addr = PCF[IMEM_ADDR_BITS+1:2];
  assign capture   = (state == FS_RUN) && !inicio && !StallD && !PCSrcD;

  // IF/ID control. The first DRAIN edge keeps END in decode; later ones flush.
  always_comb begin
    ifid_en  = 1'b0;
    ifid_clr = 1'b0;
    if (inicio) begin
      ifid_en  = 1'b1;
      ifid_clr = 1'b1;
    end else begin
      case (state)
        FS_RUN: begin
          ifid_en  = !StallD;
          ifid_clr = PCSrcD;
        end
        FS_DRAIN: begin
          ifid_en  = (drain_cnt != DW'(DRAIN_CYCLES));
          ifid_clr = 1'b1;
        end
        default: begin
          ifid_en  = 1'b0;
          ifid_clr = 1'b0;
        end
      endcase
    end
  end

  if_id_register u_if_id (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ifid_en),
    .clr      (ifid_clr),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr_q  (InstrD),
    .pc4_q    (PCPlus4D)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FS_IDLE;
      PCF         <= RESET_PC;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      instr_count <= 32'h0;
    end else if (inicio) begin
      state       <= FS_IDLE;
      PCF         <= RESET_PC;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      instr_count <= 32'h0;
    end else begin
      case (state)
        FS_IDLE: state <= FS_RUN;
        FS_RUN: begin
          // A branch redirect only counts when decode is not stalled.
          if (!StallD && PCSrcD)
            PCF <= {PCBranchD[31:2], 2'b00};
          else if (!StallF)
            PCF <= pc_plus4;
          if (capture) begin
            if (instr_count != 32'hFFFF_FFFF)
              instr_count <= instr_count + 32'd1;
            if (is_end(imem_rdata)) begin
              state     <= FS_DRAIN;
              drain_cnt <= DW'(DRAIN_CYCLES);
            end
          end
        end
        FS_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state  <= FS_HALTED;
            halted <= 1'b1;
          end
        end
        default: state <= FS_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        inicio;
  logic        StallF;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        halted;
  logic [31:0] instr_count;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] END_W = 32'hFC00_0000;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  fetch_stage #(
    .RESET_PC       (32'h0),
    .IMEM_ADDR_BITS (8),
    .DRAIN_CYCLES   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inicio      (inicio),
    .StallF      (StallF),
    .StallD      (StallD),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCPlus4D    (PCPlus4D),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] p4, input logic [31:0] cnt);
    check({tag, ".PCF"}, PCF, pc);
    check({tag, ".InstrD"}, InstrD, ins);
    check({tag, ".PCPlus4D"}, PCPlus4D, p4);
    check({tag, ".count"}, instr_count, cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
    reset_n = 1'b0; inicio = 1'b1; StallF = 1'b0; StallD = 1'b0;
    PCSrcD = 1'b0; PCBranchD = 32'h0;
    #3;
    chk4("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset.halted", {31'b0, halted}, 32'h0);

    // start sequence
    #4 reset_n = 1'b1;
    step();
    inicio = 1'b0;
    step();
    chk4("idle2run", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk4("capA", 32'h4, mem[0], 32'h4, 32'd1);
    step();
    chk4("capB", 32'h8, mem[1], 32'h8, 32'd2);

    // full stall at PCF=8, then stalled with a pending branch
    StallF = 1'b1; StallD = 1'b1;
    step();
    chk4("stall1", 32'h8, mem[1], 32'h8, 32'd2);
    step();
    chk4("stall2", 32'h8, mem[1], 32'h8, 32'd2);
    PCSrcD = 1'b1; PCBranchD = 32'h80;
    step();
    chk4("stallbr", 32'h8, mem[1], 32'h8, 32'd2);
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    step();
    chk4("capC", 32'hC, mem[2], 32'hC, 32'd3);
    step();
    chk4("capD", 32'h10, mem[3], 32'h10, 32'd4);

    // branch to unaligned target, flush then fetch from target
    PCSrcD = 1'b1; PCBranchD = 32'h43;
    step();
    chk4("branch", 32'h40, 32'h0, 32'h0, 32'd4);
    PCSrcD = 1'b0;
    step();
    chk4("tgt", 32'h44, mem[16], 32'h44, 32'd5);

    // StallF only: capture happens, PC holds
    StallF = 1'b1;
    step();
    chk4("stallF", 32'h44, mem[17], 32'h48, 32'd6);
    StallF = 1'b0;
    step();
    chk4("unstallF", 32'h48, mem[17], 32'h48, 32'd7);

    // END drain and halt
    mem[3] = END_W;
    inicio = 1'b1;
    step();
    chk4("restart", 32'h0, 32'h0, 32'h0, 32'd0);
    inicio = 1'b0;
    step();
    step();
    step();
    step();
    step();
    chk4("capEND", 32'h10, END_W, 32'h10, 32'd4);
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80;
    step();
    chk4("drain1", 32'h10, END_W, 32'h10, 32'd4);
    check("drain1.halted", {31'b0, halted}, 32'h0);
    step();
    chk4("drain2", 32'h10, 32'h0, 32'h0, 32'd4);
    step();
    check("drain3.halted", {31'b0, halted}, 32'h0);
    step();
    check("drain4.halted", {31'b0, halted}, 32'h1);
    chk4("halt", 32'h10, 32'h0, 32'h0, 32'd4);
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    step();
    step();
    check("frozen.halted", {31'b0, halted}, 32'h1);
    chk4("frozen", 32'h10, 32'h0, 32'h0, 32'd4);
    inicio = 1'b1;
    step();
    check("unhalt.halted", {31'b0, halted}, 32'h0);
    chk4("unhalt", 32'h0, 32'h0, 32'h0, 32'd0);

    // END in branch shadow is flushed
    inicio = 1'b0;
    step();
    step();
    step();
    step();
    chk4("shC", 32'hC, mem[2], 32'hC, 32'd3);
    PCSrcD = 1'b1; PCBranchD = 32'h20;
    step();
    chk4("shflush", 32'h20, 32'h0, 32'h0, 32'd3);
    PCSrcD = 1'b0;
    step();
    chk4("shtgt", 32'h24, mem[8], 32'h24, 32'd4);
    step();
    chk4("shnext", 32'h28, mem[9], 32'h28, 32'd5);
    check("sh.halted", {31'b0, halted}, 32'h0);

    // async reset between edges
    #1 reset_n = 1'b0;
    #1;
    chk4("areset", 32'h0, 32'h0, 32'h0, 32'd0);
    check("areset.halted", {31'b0, halted}, 32'h0);
    #2 reset_n = 1'b1;
    step();
    chk4("arel", 32'h0, 32'h0, 32'h0, 32'd0);
    step();
    chk4("arelA", 32'h4, mem[0], 32'h4, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
